// File: rtl/text_buffer_if.sv
// Writer-side byte stream into the character screen memory.
// The master drives bytes and the text buffer answers with ready.
interface text_buffer_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/text_buffer.sv
// Character-cell screen memory feeding the font stage.
// It takes terminal-style writes: auto-advance, CR, LF, backspace and clear screen.
module text_buffer #(
    parameter int COLS       = 20,
    parameter int ROWS       = 15,
    parameter int CELL_SHIFT = 5
) (
    input  logic            px_clk,
    input  logic            rstn,
    input  logic [9:0]      px_x,
    input  logic [9:0]      px_y,
    input  logic            activevideo,
    output logic [7:0]      char_out,
    text_buffer_if.slave    wr,
    output logic [4:0]      cursor_col,
    output logic [3:0]      cursor_row,
    output logic            busy
);
    localparam int         CELLS     = COLS * ROWS;
    localparam logic [8:0] LAST_ADDR = 9'(CELLS - 1);
    localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
    localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    logic [7:0] mem [0:CELLS-1];

    state_t     state_q, state_d;
    logic [8:0] clr_addr_q, clr_addr_d;
    logic [4:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       busy_q, wr_ready_q;
    logic [7:0] char_q;

    logic       we_s;
    logic [8:0] waddr_s;
    logic [7:0] wdata_s;
    logic [9:0] rd_col_s, rd_row_s;
    logic       rd_hit_s;
    logic [8:0] rd_addr_s;
    logic [8:0] cur_addr_s;
    logic [3:0] row_inc_s;

    // Pixel-side cell lookup; out-of-screen or blanked pixels map to no cell.
    always_comb begin
        rd_col_s  = px_x >> CELL_SHIFT;
        rd_row_s  = px_y >> CELL_SHIFT;
        rd_hit_s  = activevideo && (rd_col_s < 10'(COLS)) && (rd_row_s < 10'(ROWS));
        rd_addr_s = 9'(rd_row_s) * 9'(COLS) + 9'(rd_col_s);
    end

    // Registered pixel read; the array read sees the pre-write byte on a collision.
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            char_q <= 8'h00;
        end else if (rd_hit_s) begin
            char_q <= mem[rd_addr_s];
        end else begin
            char_q <= 8'h00;
        end
    end

    // Single write port shared by the clear sequencer and the writer.
    always_ff @(posedge px_clk) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    // Cursor address and wrapped next row.
    always_comb begin
        cur_addr_s = 9'(row_q) * 9'(COLS) + 9'(col_q);
        row_inc_s  = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
    end

    // Next-state, cursor update and write-port control.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        we_s       = 1'b0;
        waddr_s    = clr_addr_q;
        wdata_s    = 8'h20;
        case (state_q)
            ST_CLEAR: begin
                // rstn gating keeps the reset-held clocks from writing.
                we_s = rstn;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = 9'd0;
                    col_d      = 5'd0;
                    row_d      = 4'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 9'd1;
                end
            end
            ST_IDLE: begin
                if (wr.wr_valid) begin
                    case (wr.wr_data)
                        8'h0C: begin
                            state_d    = ST_CLEAR;
                            clr_addr_d = 9'd0;
                        end
                        8'h0D: col_d = 5'd0;
                        8'h0A: begin
                            col_d = 5'd0;
                            row_d = row_inc_s;
                        end
                        8'h08: begin
                            if (col_q != 5'd0) begin
                                col_d   = col_q - 5'd1;
                                we_s    = 1'b1;
                                waddr_s = cur_addr_s - 9'd1;
                                wdata_s = 8'h20;
                            end else begin
                                col_d = col_q;
                            end
                        end
                        default: begin
                            if ((wr.wr_data >= 8'h20) && (wr.wr_data <= 8'h7E)) begin
                                we_s    = 1'b1;
                                waddr_s = cur_addr_s;
                                wdata_s = wr.wr_data;
                                if (col_q == LAST_COL) begin
                                    col_d = 5'd0;
                                    row_d = row_inc_s;
                                end else begin
                                    col_d = col_q + 5'd1;
                                end
                            end else begin
                                col_d = col_q;
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = 9'd0;
            end
        endcase
    end

    // State, cursor and registered status outputs.
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= 9'd0;
            col_q      <= 5'd0;
            row_q      <= 4'd0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            busy_q     <= (state_d == ST_CLEAR);
            wr_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign char_out    = char_q;
    assign wr.wr_ready = wr_ready_q;
    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign busy        = busy_q;
endmodule
